countdown_digit_timer: RTL

//  Two-digit BCD countdown timer (00-99 s); consumer end of the one-second tick interface.

---
 rtl/countdown_digit_timer.sv | 138 +++++++++++++
 1 files changed

// File: rtl/countdown_digit_timer.sv
// Two-digit BCD countdown timer (00-99) driven by a one-second tick pulse.
// Optional macro AUTO_RELOAD_EN: reload the presets on expiry and keep running.
module countdown_digit_timer #(
  parameter logic [3:0] DEFAULT_TENS = 4'd3,
  parameter logic [3:0] DEFAULT_ONES = 4'd0
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       i_tick_in,
  output logic       o_tick_enable,
  input  logic       i_load,
  input  logic [3:0] i_load_tens,
  input  logic [3:0] i_load_ones,
  input  logic       i_start,
  input  logic       i_pause,
  output logic [3:0] o_tens,
  output logic [3:0] o_ones,
  output logic       o_running,
  output logic       o_expired
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSE, S_DONE} state_t;

  state_t     r_state, w_state_next;
  logic [3:0] r_tens, r_ones;
  logic [3:0] w_tens_next, w_ones_next;
  logic [3:0] w_load_tens, w_load_ones;
  logic [3:0] w_dec_tens, w_dec_ones;
  logic       w_is_zero, w_dec_is_zero, w_tick_run;

  // Out-of-range preset nibbles fall back to the defaults so digits stay BCD.
  assign w_load_tens = (i_load_tens > 4'd9) ? DEFAULT_TENS : i_load_tens;
  assign w_load_ones = (i_load_ones > 4'd9) ? DEFAULT_ONES : i_load_ones;

  assign w_is_zero     = (r_tens == 4'd0) && (r_ones == 4'd0);
  assign w_dec_ones    = (r_ones != 4'd0) ? r_ones - 4'd1 : 4'd9;
  assign w_dec_tens    = (r_ones != 4'd0) ? r_tens : r_tens - 4'd1;
  assign w_dec_is_zero = (r_tens == 4'd0) && (r_ones == 4'd1);
  assign w_tick_run    = (r_state == S_RUN) && i_tick_in && !w_is_zero;

`ifdef AUTO_RELOAD_EN
  logic [3:0] r_preset_tens, r_preset_ones;
  logic       r_expire_pulse;

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_preset_tens  <= DEFAULT_TENS;
      r_preset_ones  <= DEFAULT_ONES;
      r_expire_pulse <= 1'b0;
    end else begin
      if (i_load) begin
        r_preset_tens <= w_load_tens;
        r_preset_ones <= w_load_ones;
      end
      r_expire_pulse <= !i_load && w_tick_run && w_dec_is_zero;
    end
  end
`endif

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    if (i_load) begin
      w_state_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_start) w_state_next = w_is_zero ? S_DONE : S_RUN;
        end
        S_RUN: begin
          if (i_pause) w_state_next = S_PAUSE;
`ifndef AUTO_RELOAD_EN
          // Reaching 00 ends the run even when pause arrives with the last tick.
          if (w_tick_run && w_dec_is_zero) w_state_next = S_DONE;
`endif
        end
        S_PAUSE: begin
          if (i_start && !i_pause) w_state_next = w_is_zero ? S_DONE : S_RUN;
        end
        default: w_state_next = S_DONE;
      endcase
    end
  end

  always_comb begin
    w_tens_next = r_tens;
    w_ones_next = r_ones;
    if (i_load) begin
      w_tens_next = w_load_tens;
      w_ones_next = w_load_ones;
    end else if (w_tick_run) begin
`ifdef AUTO_RELOAD_EN
      if (w_dec_is_zero) begin
        w_tens_next = r_preset_tens;
        w_ones_next = r_preset_ones;
      end else begin
        w_tens_next = w_dec_tens;
        w_ones_next = w_dec_ones;
      end
`else
      w_tens_next = w_dec_tens;
      w_ones_next = w_dec_ones;
`endif
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_tens <= DEFAULT_TENS;
      r_ones <= DEFAULT_ONES;
    end else begin
      r_tens <= w_tens_next;
      r_ones <= w_ones_next;
    end
  end

  // Outputs decode the registered state, so tick_enable and running fall together.
  always_comb begin
    o_running     = (r_state == S_RUN);
    o_tick_enable = (r_state == S_RUN);
`ifdef AUTO_RELOAD_EN
    o_expired     = (r_state == S_DONE) || r_expire_pulse;
`else
    o_expired     = (r_state == S_DONE);
`endif
  end

  assign o_tens = r_tens;
  assign o_ones = r_ones;

endmodule
